// File: rtl/i2s_rx.sv
// i2s_rx: I2S record-path deserializer delivering BPS-bit samples as strobes on in_clk
module i2s_rx #(
   parameter int BPS = 24
) (
   input  logic           in_clk,
   input  logic           in_reset_n,
   input  logic           in_enable,
   input  logic           in_BCLK,
   input  logic           in_RECLRC,
   input  logic           in_RECDAT,
   output logic [BPS-1:0] out_frame,
   output logic           out_channel,
   output logic           out_ready,
   output logic           out_short
);
   localparam int CW = $clog2(BPS + 1);
   typedef logic [BPS-1:0] word_t;
   typedef logic [CW-1:0] cnt_t;
   typedef enum logic [1:0] {IDLE, ARM, SHIFT, DONE} state_t;

   state_t     state, state_nxt;
   logic [2:0] bclk_s;
   logic [1:0] lrc_s, dat_s;
   logic       lrc_prev, primed, rise, lrc_change;
   word_t      sh, sh_nxt;
   cnt_t       cnt, cnt_nxt;
   logic       ch, ch_nxt, emit, emit_nxt, short_q, short_nxt, emit_ch, emit_ch_nxt;

   assign rise       = bclk_s[1] & ~bclk_s[2];
   assign lrc_change = rise & primed & (lrc_s[1] != lrc_prev);

   // Synchronizers and LRC tracking; the first BCLK edge after reset only primes lrc_prev so a mid-slot start never arms
   always_ff @(posedge in_clk or negedge in_reset_n)
      if (!in_reset_n) begin
         bclk_s   <= '0;
         lrc_s    <= '0;
         dat_s    <= '0;
         lrc_prev <= 1'b0;
         primed   <= 1'b0;
      end else begin
         bclk_s <= {bclk_s[1:0], in_BCLK};
         lrc_s  <= {lrc_s[0], in_RECLRC};
         dat_s  <= {dat_s[0], in_RECDAT};
         if (rise) begin
            lrc_prev <= lrc_s[1];
            primed   <= 1'b1;
         end
      end

   // Framing FSM: the bit coinciding with an LRC change closes the old slot, the next bit is the new MSB
   always_comb begin
      state_nxt   = state;
      sh_nxt      = sh;
      cnt_nxt     = cnt;
      ch_nxt      = ch;
      emit_nxt    = 1'b0;
      short_nxt   = 1'b0;
      emit_ch_nxt = emit_ch;
      if (!in_enable)
         state_nxt = IDLE;
      else if (rise)
         case (state)
            IDLE: if (lrc_change) begin
               state_nxt = ARM;
               ch_nxt    = lrc_s[1];
            end
            ARM: begin
               sh_nxt    = {dat_s[1], {(BPS-1){1'b0}}};
               cnt_nxt   = cnt_t'(1);
               state_nxt = SHIFT;
            end
            SHIFT: begin
               sh_nxt  = sh | (word_t'(dat_s[1]) << (cnt_t'(BPS - 1) - cnt));
               cnt_nxt = cnt + 1'b1;
               if (lrc_change || cnt_nxt == cnt_t'(BPS)) begin
                  emit_nxt    = 1'b1;
                  short_nxt   = cnt_nxt != cnt_t'(BPS);
                  emit_ch_nxt = ch;
                  state_nxt   = lrc_change ? ARM : DONE;
                  ch_nxt      = lrc_change ? lrc_s[1] : ch;
               end
            end
            DONE: if (lrc_change) begin
               state_nxt = ARM;
               ch_nxt    = lrc_s[1];
            end
            default: state_nxt = IDLE;
         endcase
   end

   // Capture state register
   always_ff @(posedge in_clk or negedge in_reset_n)
      if (!in_reset_n) begin
         state   <= IDLE;
         sh      <= '0;
         cnt     <= '0;
         ch      <= 1'b0;
         emit    <= 1'b0;
         short_q <= 1'b0;
         emit_ch <= 1'b0;
      end else begin
         state   <= state_nxt;
         sh      <= sh_nxt;
         cnt     <= cnt_nxt;
         ch      <= ch_nxt;
         emit    <= emit_nxt;
         short_q <= short_nxt;
         emit_ch <= emit_ch_nxt;
      end

   // Output register: strobes last one cycle, word and channel hold until the next strobe
   always_ff @(posedge in_clk or negedge in_reset_n)
      if (!in_reset_n) begin
         out_frame   <= '0;
         out_channel <= 1'b0;
         out_ready   <= 1'b0;
         out_short   <= 1'b0;
      end else begin
         out_ready <= emit;
         out_short <= short_q;
         if (emit) begin
            out_frame   <= sh;
            out_channel <= emit_ch;
         end
      end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed I2S record stream checked against a slot-level model of the receiver
module tb_i2s_rx;
   localparam int BPS = 24;
   localparam int H   = 50;

   logic in_clk = 1'b0, in_reset_n = 1'b1, in_enable = 1'b1;
   logic in_BCLK = 1'b0, in_RECLRC = 1'b0, in_RECDAT = 1'b0;
   logic [BPS-1:0] out_frame;
   logic out_channel, out_ready, out_short;

   typedef struct {
      logic [BPS-1:0] f;
      logic           ch;
      logic           sh;
      longint         t;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   logic [BPS-1:0] rx_f[$];
   logic rx_ch[$];
   logic rx_sh[$];
   int n_cmp = 0, n_bad = 0;
   int b;
   logic [23:0] lw, rw;

   i2s_rx #(.BPS(BPS)) dut (
      .in_clk(in_clk),
      .in_reset_n(in_reset_n),
      .in_enable(in_enable),
      .in_BCLK(in_BCLK),
      .in_RECLRC(in_RECLRC),
      .in_RECDAT(in_RECDAT),
      .out_frame(out_frame),
      .out_channel(out_channel),
      .out_ready(out_ready),
      .out_short(out_short)
   );

   always #5 in_clk = ~in_clk;

   // Slot content left-justified to BPS: truncate long slots, zero-fill short ones
   function automatic logic [BPS-1:0] model_frame(input logic [31:0] bits, input int len);
      logic [63:0] w;
      w = {32'h0, bits};
      if (len >= BPS) w = w >> (len - BPS);
      else w = w << (BPS - len);
      return w[BPS-1:0];
   endfunction

   // Strobe lands on the 4th in_clk rising edge after the BCLK rise (edges at 5 + 10k)
   function automatic longint strobe_at(input longint t);
      return t + (10 - (t - 5) % 10) + 30;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Bits first..stop-1 of a slot; LRC shows next channel on the last bit
   task automatic send_slot(input logic ch, input logic [31:0] bits, input int len, input logic nch,
                            input bit expect_it, input int first = 0, input int stop = 32,
                            input int en_off = -1, input int en_on = -1);
      int last;
      last = (len < stop) ? len : stop;
      for (int i = first; i < last; i++) begin
         if (i == en_off) in_enable = 1'b0;
         if (i == en_on) in_enable = 1'b1;
         if (expect_it && i == ((len < BPS) ? len : BPS) - 1)
            exp_q.push_back('{model_frame(bits, len), ch, len < BPS, strobe_at($time + H)});
         in_BCLK   = 1'b0;
         in_RECLRC = (i == len - 1) ? nch : ch;
         in_RECDAT = bits[len-1-i];
         #H in_BCLK = 1'b1;
         #H;
      end
   endtask

   always @(negedge in_clk)
      if (out_ready) begin
         rx_f.push_back(out_frame);
         rx_ch.push_back(out_channel);
         rx_sh.push_back(out_short);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got frame %h ch %0d, want no strobe at %0t", out_frame, out_channel, $time);
         end else begin
            e = exp_q.pop_front();
            check("frame", out_frame, e.f);
            check("channel", out_channel, e.ch);
            check("short", out_short, e.sh);
            check("latency", $time - 5, e.t);
         end
      end else
         check("short_idle", out_short, 0);

   initial begin
      #2 in_reset_n = 1'b0;
      in_RECLRC = 1'b1;
      #1 check("rst_frame", out_frame, 0);
      check("rst_channel", out_channel, 0);
      check("rst_ready", out_ready, 0);
      check("rst_short", out_short, 0);
      #20 in_reset_n = 1'b1;
      send_slot(1'b1, 32'h0, 32, 1'b0, 1'b0, 20);
      b = rx_f.size();
      send_slot(1'b0, {24'hA5C3F0, 8'h5A}, 32, 1'b1, 1'b1);
      send_slot(1'b1, {24'h0F1E2D, 8'hC3}, 32, 1'b0, 1'b1);
      check("startup_no_partial", b, 0);
      check("basic_cnt", rx_f.size() - b, 2);
      check("basic_left", rx_f[b], 24'hA5C3F0);
      check("basic_left_ch", rx_ch[b], 0);
      check("basic_right", rx_f[b+1], 24'h0F1E2D);
      check("basic_right_ch", rx_ch[b+1], 1);
      b = rx_f.size();
      lw = 24'hC0FFEE;
      rw = 24'h0F0F0F;
      for (int f = 0; f < 8; f++) begin
         send_slot(1'b0, {8'h0, lw}, 24, 1'b1, 1'b1);
         send_slot(1'b1, {8'h0, rw}, 24, 1'b0, 1'b1);
         lw = {lw[22:0], lw[23]} ^ 24'h5A5A5A;
         rw = rw + 24'h010203;
      end
      check("exact_cnt", rx_f.size() - b, 16);
      check("exact_first", rx_f[b], 24'hC0FFEE);
      check("exact_second", rx_f[b+1], 24'h0F0F0F);
      for (int k = 0; k < 16; k++) check("exact_alt_ch", rx_ch[b+k], k % 2);
      b = rx_f.size();
      send_slot(1'b0, 32'h0000BEEF, 16, 1'b1, 1'b1);
      send_slot(1'b1, {24'h13579B, 8'h00}, 32, 1'b0, 1'b1);
      check("short_cnt", rx_f.size() - b, 2);
      check("short_frame", rx_f[b], 24'hBEEF00);
      check("short_flag", rx_sh[b], 1);
      check("short_ch", rx_ch[b], 0);
      check("after_short", rx_f[b+1], 24'h13579B);
      check("after_short_flag", rx_sh[b+1], 0);
      b = rx_f.size();
      send_slot(1'b0, {24'hDEAD01, 8'h00}, 32, 1'b1, 1'b0, 0, 32, 10);
      send_slot(1'b1, {24'hFACE02, 8'h00}, 32, 1'b0, 1'b0, 0, 32, -1, 12);
      send_slot(1'b0, {24'h600DF0, 8'h11}, 32, 1'b1, 1'b1);
      send_slot(1'b1, {24'h2468AC, 8'h00}, 32, 1'b0, 1'b1);
      check("enable_cnt", rx_f.size() - b, 2);
      check("enable_left", rx_f[b], 24'h600DF0);
      check("enable_left_ch", rx_ch[b], 0);
      send_slot(1'b0, 32'hFFFFFFFF, 32, 1'b1, 1'b0, 0, 12);
      in_reset_n = 1'b0;
      #1 check("midrst_frame", out_frame, 0);
      check("midrst_channel", out_channel, 0);
      check("midrst_ready", out_ready, 0);
      check("midrst_short", out_short, 0);
      #39 in_reset_n = 1'b1;
      b = rx_f.size();
      send_slot(1'b0, 32'hFFFFFFFF, 32, 1'b1, 1'b0, 12);
      send_slot(1'b1, {24'h0ABCDE, 8'h00}, 32, 1'b0, 1'b1);
      send_slot(1'b0, {24'h55AA33, 8'h00}, 32, 1'b1, 1'b1);
      check("reset_cnt", rx_f.size() - b, 2);
      check("reset_first", rx_f[b], 24'h0ABCDE);
      check("reset_first_ch", rx_ch[b], 1);
      #200;
      check("pending", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receive-side I2S deserializer: captures serial audio words from the codec record path (bit clock, record LR clock, record data) and delivers parallel BPS-bit samples, one per channel slot, as single-cycle pulses on the internal system clock. It is the counterpart of the I2S playback transmitter. Its output pair (out_frame, out_ready) connects directly to a FIFO write port (din/wr_en), so recorded audio can enter the existing sample pipeline.

## Interface
- BPS, 24, bits captured per channel slot; also the output word width.
- in_clk  input  1  system clock (61.44 MHz); all logic runs on its rising edge.
- in_reset_n  input  1  asynchronous, active-low reset.
- in_enable  input  1  capture enable; level-sensitive.
- in_BCLK  input  1  I2S bit clock; asynchronous to in_clk.
- in_RECLRC  input  1  record LR clock: 0 = left slot, 1 = right slot.
- in_RECDAT  input  1  record serial data, MSB first.
- out_frame  output  BPS  captured sample, left-justified.
- out_channel  output  1  slot of out_frame: 0 = left, 1 = right.
- out_ready  output  1  one-cycle strobe; out_frame and out_channel are valid in that cycle.
- out_short  output  1  one-cycle strobe, asserted together with out_ready when the slot ended before BPS bits were captured.

## Operation
- **Input synchronization.** in_BCLK, in_RECLRC and in_RECDAT each pass through an identical 2-flop synchronizer, followed by a third register on BCLK.
  - A BCLK rising event is sync2 = 1 and sync3 = 0.
  - LRC and DAT are taken from the synchronized sync2 values in the same cycle.
- **Per BCLK rising event:**
  - Register the sampled LRC into lrc_prev.
  - lrc_change = (sampled LRC != lrc_prev).
- **I2S framing.**
  - The bit that coincides with an LRC change is the last bit of the previous slot.
  - The MSB of the new slot arrives on the next BCLK rising event.
  - The new slot's channel is the LRC value after the change.
- **State machine.** States are IDLE, ARM, SHIFT and DONE. Reset state is IDLE.
  - IDLE: wait for lrc_change with in_enable = 1, then go to ARM and latch the channel.
  - ARM: on the next BCLK rising event, shift in DAT as the MSB, set bit_cnt = 1 and go to SHIFT.
  - SHIFT: on each BCLK rising event with no lrc_change, shift DAT in and increment bit_cnt.
    - When bit_cnt reaches BPS, emit the word (out_short = 0) and go to DONE.
  - SHIFT with lrc_change and bit_cnt < BPS (short slot):
    - The bit arriving with the change is still captured.
    - The partial word is emitted left-justified, with the unfilled LSBs set to 0 and out_short = 1.
    - Go directly to ARM with the new channel latched.
  - DONE: ignore data bits (slot longer than BPS is legal; extra bits are dropped).
    - On lrc_change, go to ARM with the new channel latched.
- **Counter.** bit_cnt is $clog2(BPS+1) bits wide and saturates at BPS. It never wraps.
- **Enable.** in_enable = 0 in any state forces IDLE in the next cycle.
  - A partial word is discarded with no strobe.
  - After re-enable, capture resumes only at the next lrc_change, so no partial slot is ever emitted.
- **Reset mid-word.** Assertion immediately clears the shift register, counter, state and all outputs. No strobe is produced for the interrupted word.

## Timing
- Reset values:
  - out_frame = 0
  - out_channel = 0
  - out_ready = 0
  - out_short = 0
  - state = IDLE
  - lrc_prev = 0
  - all synchronizer flops = 0
- Latency: out_ready rises on the 4th in_clk rising edge after the in_BCLK rising edge that delivers the word's last bit (2 synchronizer edges, 1 edge-detect/shift edge, 1 output-register edge).
- out_ready and out_short are high for exactly one in_clk cycle per word.
- Consecutive strobes are at least 4 in_clk cycles apart.
- out_frame and out_channel hold their value until the next strobe.
- in_BCLK high and low phases must each be ≥ 2 in_clk periods. 3.072 MHz BCLK at 61.44 MHz gives 10 cycles per phase.
- in_RECLRC and in_RECDAT change only on in_BCLK falling edges.
- The simultaneous case (last bit of a slot coincides with lrc_change) is defined above: the bit is kept and the new slot arms in the same event.
- No back-pressure: the consumer must accept every strobe.

## Test plan
- **Basic stereo.** BPS=24, 64-BCLK frames (32 bits per slot), left = 0xA5C3F0, right = 0x0F1E2D.
  - Required: strobes with (0xA5C3F0, ch0) then (0x0F1E2D, ch1), out_short = 0.
  - Each strobe arrives 4 in_clk edges after the 24th-bit BCLK rising edge.
- **Exact-length slots.** 48-BCLK frames, 24 bits per slot, continuous stream of 8 frames.
  - Required: 16 strobes, alternating channels, all values correct, no drops.
- **Short slot.** Left slot of only 16 bits carrying 0xBEEF.
  - Required: out_frame = 0xBEEF00, out_short = 1, ch0.
  - The following right slot is captured normally.
- **Enable mid-slot.** Drop in_enable after 10 bits of the left slot, then re-raise it mid-right-slot.
  - Required: no strobe for either slot; the next left slot is received correctly.
- **Reset mid-word.** Assert in_reset_n = 0 after 12 bits.
  - Required: all outputs are 0 immediately and no strobe appears.
  - After release, the first strobe corresponds to the first complete slot that follows an LRC change.
- **Startup alignment.** Release reset with RECLRC already 1, mid-right-slot.
  - Required: the first strobe is a left-channel word; no partial right word is emitted.
